// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the second-generation system controller:
// command opcodes, the error response byte and the FSM state encodings.
package sys_ctrl_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

    typedef enum logic [3:0] {
        RX_IDLE,
        RX_WR_ADDR,
        RX_WR_DATA,
        RX_RD_ADDR,
        RX_RD_WAIT,
        RX_OP_A,
        RX_OP_B,
        RX_FUN,
        RX_ALU_WAIT,
        RX_PUSH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_READY,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/sys_ctrl_tx_fifo.sv
// Response byte FIFO: array storage with a registered read port that doubles
// as the UART TX data holding register, plus a free-slot count.
module sys_ctrl_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      free
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign free  = (AW+1)'(DEPTH) - count_reg;
    // A write into a full FIFO is accepted when a pop frees a slot in the same cycle.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sys_ctrl_gen2.sv
// System controller: decodes framed UART commands into RegFile/ALU strobes,
// queues responses in a byte FIFO and drains them to the UART transmitter.
module sys_ctrl_gen2
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int RES_BYTES  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           uart_rx_p_data,
    input  logic                            uart_rx_d_vld,
    input  logic                            uart_tx_busy,
    input  logic [DATA_WIDTH-1:0]           rf_rdData,
    input  logic                            rf_rdData_vld,
    input  logic [RES_BYTES*DATA_WIDTH-1:0] alu_out,
    input  logic                            alu_out_valid,
    output logic                            alu_en,
    output logic [3:0]                      alu_fun,
    output logic                            clk_gate_en,
    output logic [RF_ADDR-1:0]              rf_address,
    output logic                            rf_wrEn,
    output logic                            rf_rdEn,
    output logic [DATA_WIDTH-1:0]           rf_wrData,
    output logic [DATA_WIDTH-1:0]           uart_tx_p_data,
    output logic                            uart_tx_d_vld,
    output logic                            clk_div_en,
    output logic                            err_flag
);
    localparam int RES_W  = RES_BYTES * DATA_WIDTH;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int PCNT_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t             rx_state_reg, rx_state_next;
    tx_state_t             tx_state_reg, tx_state_next;
    logic [RF_ADDR-1:0]    wr_addr_reg, wr_addr_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [RES_W-1:0]      res_reg, res_next;
    logic [PCNT_W-1:0]     pcnt_reg, pcnt_next;
    logic [RF_ADDR-1:0]    rf_address_reg, rf_address_next;
    logic [DATA_WIDTH-1:0] rf_wrdata_reg, rf_wrdata_next;
    logic                  rf_wren_reg, rf_wren_next;
    logic                  rf_rden_reg, rf_rden_next;
    logic                  alu_en_reg, alu_en_next;
    logic [3:0]            alu_fun_reg, alu_fun_next;
    logic                  err_reg, err_next;
    logic                  tx_vld_reg, tx_vld_next;
    logic                  clk_div_reg;

    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [FREE_W-1:0]     fifo_free;

    logic                  timed_out;
    logic                  room_one;
    logic                  room_res;
    logic [RF_ADDR-1:0]    rx_addr;

    sys_ctrl_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign room_one  = (fifo_free != '0);
    assign room_res  = (fifo_free >= FREE_W'(RES_BYTES));
    assign rx_addr   = uart_rx_p_data[RF_ADDR-1:0];

    // Command decoder, timeout counter and response pushes.
    always_comb begin
        rx_state_next   = rx_state_reg;
        wr_addr_next    = wr_addr_reg;
        cnt_next        = cnt_reg;
        res_next        = res_reg;
        pcnt_next       = pcnt_reg;
        rf_address_next = rf_address_reg;
        rf_wrdata_next  = rf_wrdata_reg;
        rf_wren_next    = 1'b0;
        rf_rden_next    = 1'b0;
        alu_en_next     = 1'b0;
        alu_fun_next    = alu_fun_reg;
        err_next        = err_reg;
        fifo_wr_en      = 1'b0;
        fifo_wr_data    = '0;

        case (rx_state_reg)
            RX_IDLE: begin
                if (uart_rx_d_vld) begin
                    if (uart_rx_p_data == DATA_WIDTH'(OP_RF_WR)) begin
                        rx_state_next = RX_WR_ADDR;
                    end else if (uart_rx_p_data == DATA_WIDTH'(OP_RF_RD)) begin
                        rx_state_next = RX_RD_ADDR;
                    end else if (uart_rx_p_data == DATA_WIDTH'(OP_ALU_OP)) begin
                        rx_state_next = RX_OP_A;
                    end else if (uart_rx_p_data == DATA_WIDTH'(OP_ALU_NOP)) begin
                        rx_state_next = RX_FUN;
                    end
                end
            end
            RX_WR_ADDR: begin
                if (uart_rx_d_vld) begin
                    wr_addr_next  = rx_addr;
                    rx_state_next = RX_WR_DATA;
                end
            end
            RX_WR_DATA: begin
                if (uart_rx_d_vld) begin
                    rf_wren_next    = 1'b1;
                    rf_address_next = wr_addr_reg;
                    rf_wrdata_next  = uart_rx_p_data;
                    rx_state_next   = RX_IDLE;
                end
            end
            RX_RD_ADDR: begin
                if (uart_rx_d_vld) begin
                    rf_rden_next    = 1'b1;
                    rf_address_next = rx_addr;
                    cnt_next        = '0;
                    rx_state_next   = RX_RD_WAIT;
                end
            end
            RX_RD_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (rf_rdData_vld) begin
                    if (room_one) begin
                        fifo_wr_en   = 1'b1;
                        fifo_wr_data = rf_rdData;
                    end else begin
                        err_next = 1'b1;
                    end
                    rx_state_next = RX_IDLE;
                end else if (timed_out) begin
                    fifo_wr_en    = room_one;
                    fifo_wr_data  = DATA_WIDTH'(ERR_BYTE);
                    err_next      = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            RX_OP_A: begin
                if (uart_rx_d_vld) begin
                    rf_wren_next    = 1'b1;
                    rf_address_next = RF_ADDR'(0);
                    rf_wrdata_next  = uart_rx_p_data;
                    rx_state_next   = RX_OP_B;
                end
            end
            RX_OP_B: begin
                if (uart_rx_d_vld) begin
                    rf_wren_next    = 1'b1;
                    rf_address_next = RF_ADDR'(1);
                    rf_wrdata_next  = uart_rx_p_data;
                    rx_state_next   = RX_FUN;
                end
            end
            RX_FUN: begin
                if (uart_rx_d_vld) begin
                    alu_fun_next  = uart_rx_p_data[3:0];
                    alu_en_next   = 1'b1;
                    cnt_next      = '0;
                    rx_state_next = RX_ALU_WAIT;
                end
            end
            RX_ALU_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (alu_out_valid) begin
                    // The whole result is queued or none of it is.
                    if (room_res) begin
                        res_next      = alu_out;
                        pcnt_next     = '0;
                        rx_state_next = RX_PUSH;
                    end else begin
                        err_next      = 1'b1;
                        rx_state_next = RX_IDLE;
                    end
                end else if (timed_out) begin
                    fifo_wr_en    = room_one;
                    fifo_wr_data  = DATA_WIDTH'(ERR_BYTE);
                    err_next      = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            RX_PUSH: begin
                fifo_wr_en   = 1'b1;
                fifo_wr_data = res_reg[DATA_WIDTH-1:0];
                res_next     = res_reg >> DATA_WIDTH;
                pcnt_next    = pcnt_reg + 1'b1;
                if (pcnt_reg == PCNT_W'(RES_BYTES - 1)) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // TX drain: one byte per complete busy handshake of the UART transmitter.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_vld_next   = 1'b0;
        fifo_rd_en    = 1'b0;
        case (tx_state_reg)
            TX_READY: begin
                if (!fifo_empty && !uart_tx_busy) begin
                    fifo_rd_en    = 1'b1;
                    tx_vld_next   = 1'b1;
                    tx_state_next = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    tx_state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    tx_state_next = TX_READY;
                end
            end
            default: tx_state_next = TX_READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg   <= RX_IDLE;
            tx_state_reg   <= TX_READY;
            wr_addr_reg    <= '0;
            cnt_reg        <= '0;
            res_reg        <= '0;
            pcnt_reg       <= '0;
            rf_address_reg <= '0;
            rf_wrdata_reg  <= '0;
            rf_wren_reg    <= 1'b0;
            rf_rden_reg    <= 1'b0;
            alu_en_reg     <= 1'b0;
            alu_fun_reg    <= '0;
            err_reg        <= 1'b0;
            tx_vld_reg     <= 1'b0;
            clk_div_reg    <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            tx_state_reg   <= tx_state_next;
            wr_addr_reg    <= wr_addr_next;
            cnt_reg        <= cnt_next;
            res_reg        <= res_next;
            pcnt_reg       <= pcnt_next;
            rf_address_reg <= rf_address_next;
            rf_wrdata_reg  <= rf_wrdata_next;
            rf_wren_reg    <= rf_wren_next;
            rf_rden_reg    <= rf_rden_next;
            alu_en_reg     <= alu_en_next;
            alu_fun_reg    <= alu_fun_next;
            err_reg        <= err_next;
            tx_vld_reg     <= tx_vld_next;
            clk_div_reg    <= 1'b1;
        end
    end

    assign alu_en         = alu_en_reg;
    assign alu_fun        = alu_fun_reg;
    assign clk_gate_en    = (rx_state_reg == RX_FUN) || (rx_state_reg == RX_ALU_WAIT);
    assign rf_address     = rf_address_reg;
    assign rf_wrEn        = rf_wren_reg;
    assign rf_rdEn        = rf_rden_reg;
    assign rf_wrData      = rf_wrdata_reg;
    assign uart_tx_p_data = fifo_rd_data;
    assign uart_tx_d_vld  = tx_vld_reg;
    assign clk_div_en     = clk_div_reg;
    assign err_flag       = err_reg;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Directed bench for sys_ctrl_gen2: table of single commands plus hand-written
// timeout, FIFO overflow and mid-transaction reset sequences.
module tb_sys_ctrl_gen2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  uart_rx_p_data;
    logic        uart_rx_d_vld;
    logic        uart_tx_busy;
    logic [7:0]  rf_rdData;
    logic        rf_rdData_vld;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        clk_gate_en;
    logic [3:0]  rf_address;
    logic        rf_wrEn;
    logic        rf_rdEn;
    logic [7:0]  rf_wrData;
    logic [7:0]  uart_tx_p_data;
    logic        uart_tx_d_vld;
    logic        clk_div_en;
    logic        err_flag;

    logic        hold_busy;
    logic        model_busy;
    logic        alu_respond;
    logic [7:0]  rd_val;
    logic [15:0] alu_val;

    int checks   = 0;
    int failures = 0;

    logic [11:0] wr_q [$];
    logic [3:0]  rd_q [$];
    logic [3:0]  fun_q [$];
    logic [7:0]  tx_q [$];

    typedef struct {
        logic [3:0][7:0]  cmd;
        int               ncmd;
        logic [7:0]       rdv;
        logic [15:0]      aluv;
        int               nwr;
        logic [1:0][11:0] wr;
        int               nrd;
        logic [3:0]       ra;
        int               nalu;
        logic [3:0]       fun;
        int               ntx;
        logic [1:0][7:0]  tx;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    assign uart_tx_busy = hold_busy | model_busy;

    sys_ctrl_gen2 dut (
        .clk            (clk),
        .reset          (reset),
        .uart_rx_p_data (uart_rx_p_data),
        .uart_rx_d_vld  (uart_rx_d_vld),
        .uart_tx_busy   (uart_tx_busy),
        .rf_rdData      (rf_rdData),
        .rf_rdData_vld  (rf_rdData_vld),
        .alu_out        (alu_out),
        .alu_out_valid  (alu_out_valid),
        .alu_en         (alu_en),
        .alu_fun        (alu_fun),
        .clk_gate_en    (clk_gate_en),
        .rf_address     (rf_address),
        .rf_wrEn        (rf_wrEn),
        .rf_rdEn        (rf_rdEn),
        .rf_wrData      (rf_wrData),
        .uart_tx_p_data (uart_tx_p_data),
        .uart_tx_d_vld  (uart_tx_d_vld),
        .clk_div_en     (clk_div_en),
        .err_flag       (err_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx_p_data = b;
        uart_rx_d_vld  = 1'b1;
        @(negedge clk);
        uart_rx_d_vld  = 1'b0;
    endtask

    task automatic clear_q();
        wr_q.delete();
        rd_q.delete();
        fun_q.delete();
        tx_q.delete();
    endtask

    function automatic vec_t mk(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3, input int ncmd,
                                input logic [7:0] rdv, input logic [15:0] aluv,
                                input int nwr, input logic [11:0] w0, input logic [11:0] w1,
                                input int nrd, input logic [3:0] ra,
                                input int nalu, input logic [3:0] fun,
                                input int ntx, input logic [7:0] t0, input logic [7:0] t1);
        vec_t r;
        r.cmd[0] = c0; r.cmd[1] = c1; r.cmd[2] = c2; r.cmd[3] = c3;
        r.ncmd = ncmd; r.rdv = rdv; r.aluv = aluv;
        r.nwr = nwr; r.wr[0] = w0; r.wr[1] = w1;
        r.nrd = nrd; r.ra = ra; r.nalu = nalu; r.fun = fun;
        r.ntx = ntx; r.tx[0] = t0; r.tx[1] = t1;
        return r;
    endfunction

    // Transaction monitor: one line per RF write and per transmitted byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (rf_wrEn) begin
                wr_q.push_back({rf_address, rf_wrData});
                $display("RF_WR addr=%0h data=%02h t=%0t", rf_address, rf_wrData, $time);
            end
            if (rf_rdEn) rd_q.push_back(rf_address);
            if (alu_en) fun_q.push_back(alu_fun);
            if (uart_tx_d_vld) begin
                tx_q.push_back(uart_tx_p_data);
                $display("TX byte=%02h t=%0t", uart_tx_p_data, $time);
            end
        end
    end

    // UART TX model: busy goes high the cycle after a strobe, for three cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_d_vld && !reset) begin
                @(negedge clk);
                model_busy = 1'b1;
                repeat (3) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // RegFile read responder: data valid three cycles after the read strobe.
    initial begin
        rf_rdData     = 8'h00;
        rf_rdData_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rf_rdEn && !reset) begin
                repeat (2) @(negedge clk);
                rf_rdData     = rd_val;
                rf_rdData_vld = 1'b1;
                @(negedge clk);
                rf_rdData_vld = 1'b0;
            end
        end
    end

    // ALU responder: result valid three cycles after alu_en when enabled.
    initial begin
        alu_out       = 16'h0000;
        alu_out_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_en && alu_respond && !reset) begin
                repeat (2) @(negedge clk);
                alu_out       = alu_val;
                alu_out_valid = 1'b1;
                @(negedge clk);
                alu_out_valid = 1'b0;
            end
        end
    end

    initial begin
        int  lat;
        bit  seen;
        reset          = 1'b1;
        uart_rx_p_data = 8'h00;
        uart_rx_d_vld  = 1'b0;
        hold_busy      = 1'b0;
        alu_respond    = 1'b1;
        rd_val         = 8'h00;
        alu_val        = 16'h0000;

        vecs[0] = mk(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 8'h00, 16'h0000,
                     1, {4'h5, 8'h3C}, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        vecs[1] = mk(8'hBB, 8'h05, 8'h00, 8'h00, 2, 8'h3C, 16'h0000,
                     0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
        vecs[2] = mk(8'hCC, 8'h10, 8'h20, 8'h00, 4, 8'h00, 16'h0030,
                     2, {4'h0, 8'h10}, {4'h1, 8'h20}, 0, 4'h0, 1, 4'h0, 2, 8'h30, 8'h00);
        vecs[3] = mk(8'h55, 8'hAA, 8'hF7, 8'hA5, 4, 8'h00, 16'h0000,
                     1, {4'h7, 8'hA5}, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
        vecs[4] = mk(8'hDD, 8'h13, 8'h00, 8'h00, 2, 8'h00, 16'hBEEF,
                     0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h3, 2, 8'hEF, 8'hBE);
        vecs[5] = mk(8'hCC, 8'hFF, 8'h01, 8'h3A, 4, 8'h00, 16'h1234,
                     2, {4'h0, 8'hFF}, {4'h1, 8'h01}, 0, 4'h0, 1, 4'hA, 2, 8'h34, 8'h12);
        vecs[6] = mk(8'hBB, 8'h9C, 8'h00, 8'h00, 2, 8'h77, 16'h0000,
                     0, 12'h000, 12'h000, 1, 4'hC, 0, 4'h0, 1, 8'h77, 8'h00);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({rf_wrEn, rf_rdEn, alu_en, clk_gate_en, uart_tx_d_vld, clk_div_en, err_flag}), 32'h0);
        check("reset_buses", 32'({rf_address, rf_wrData, alu_fun, uart_tx_p_data}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("clk_div_en_after_reset", 32'(clk_div_en), 32'h1);

        // Table-driven single commands
        for (int v = 0; v < NV; v++) begin
            clear_q();
            rd_val  = vecs[v].rdv;
            alu_val = vecs[v].aluv;
            for (int k = 0; k < vecs[v].ncmd; k++) send_byte(vecs[v].cmd[k]);
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_nwr", v), 32'(wr_q.size()), 32'(vecs[v].nwr));
            for (int k = 0; k < vecs[v].nwr && k < wr_q.size(); k++)
                check($sformatf("v%0d_wr%0d", v, k), 32'(wr_q[k]), 32'(vecs[v].wr[k]));
            check($sformatf("v%0d_nrd", v), 32'(rd_q.size()), 32'(vecs[v].nrd));
            if (vecs[v].nrd > 0 && rd_q.size() > 0)
                check($sformatf("v%0d_rd_addr", v), 32'(rd_q[0]), 32'(vecs[v].ra));
            check($sformatf("v%0d_nalu", v), 32'(fun_q.size()), 32'(vecs[v].nalu));
            if (vecs[v].nalu > 0 && fun_q.size() > 0)
                check($sformatf("v%0d_fun", v), 32'(fun_q[0]), 32'(vecs[v].fun));
            check($sformatf("v%0d_ntx", v), 32'(tx_q.size()), 32'(vecs[v].ntx));
            for (int k = 0; k < vecs[v].ntx && k < tx_q.size(); k++)
                check($sformatf("v%0d_tx%0d", v, k), 32'(tx_q[k]), 32'(vecs[v].tx[k]));
            check($sformatf("v%0d_err", v), 32'(err_flag), 32'h0);
            $display("VEC %0d wr=%0d rd=%0d alu=%0d tx=%0d", v, wr_q.size(), rd_q.size(), fun_q.size(), tx_q.size());
        end
        check("alu_fun_held", 32'(alu_fun), 32'hA);

        // ALU timeout: error byte 256 cycles after alu_en
        alu_respond = 1'b0;
        clear_q();
        send_byte(8'hDD);
        send_byte(8'h02);
        check("timeout_gate_en", 32'(clk_gate_en), 32'h1);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 400 && !seen; c++) begin
            @(negedge clk);
            if (uart_tx_d_vld) begin
                seen = 1'b1;
                lat  = c;
                check("timeout_byte", 32'(uart_tx_p_data), 32'hEE);
            end
        end
        check("timeout_seen", 32'(seen), 32'h1);
        check("timeout_latency", 32'(lat), 32'd256);
        check("timeout_err_flag", 32'(err_flag), 32'h1);
        check("timeout_gate_off", 32'(clk_gate_en), 32'h0);
        alu_respond = 1'b1;
        repeat (10) @(negedge clk);
        clear_q();
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h99);
        repeat (10) @(negedge clk);
        check("post_timeout_nwr", 32'(wr_q.size()), 32'h1);
        if (wr_q.size() > 0) check("post_timeout_wr", 32'(wr_q[0]), 32'h399);
        check("err_sticky", 32'(err_flag), 32'h1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("err_cleared_by_reset", 32'(err_flag), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // FIFO overflow: four 2-byte responses fit, the fifth is dropped
        hold_busy = 1'b1;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            alu_val = {8'(8'h40 + i), 8'(8'h10 + i)};
            send_byte(8'hCC);
            send_byte(8'(i));
            send_byte(8'(i));
            send_byte(8'h00);
            repeat (12) @(negedge clk);
            if (i == 3) check("ovf_err_before_5th", 32'(err_flag), 32'h0);
        end
        check("ovf_err_after_5th", 32'(err_flag), 32'h1);
        check("ovf_no_tx_while_busy", 32'(tx_q.size()), 32'h0);
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (tx_q.size() >= 8) seen = 1'b1;
        end
        check("ovf_drain_done", 32'(seen), 32'h1);
        repeat (30) @(negedge clk);
        check("ovf_tx_count", 32'(tx_q.size()), 32'd8);
        for (int i = 0; i < 4 && tx_q.size() >= 8; i++) begin
            check($sformatf("ovf_tx_lo%0d", i), 32'(tx_q[2*i]), 32'(8'h10 + i));
            check($sformatf("ovf_tx_hi%0d", i), 32'(tx_q[2*i+1]), 32'(8'h40 + i));
        end

        // Reset while waiting for operand B
        send_byte(8'hCC);
        send_byte(8'h11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_opb_strobes", 32'({rf_wrEn, rf_rdEn, alu_en, clk_gate_en, uart_tx_d_vld, clk_div_en, err_flag}), 32'h0);
        check("rst_opb_buses", 32'({rf_address, rf_wrData, alu_fun, uart_tx_p_data}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        clear_q();
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (10) @(negedge clk);
        check("rst_opb_idle_no_wr", 32'(wr_q.size()), 32'h0);
        check("rst_opb_idle_no_alu", 32'(fun_q.size()), 32'h0);

        // Reset while the transmitter waits for busy to drop, with a byte still queued
        hold_busy = 1'b1;
        rd_val    = 8'h5A;
        send_byte(8'hBB);
        send_byte(8'h04);
        repeat (10) @(negedge clk);
        send_byte(8'hBB);
        send_byte(8'h05);
        repeat (10) @(negedge clk);
        clear_q();
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (uart_tx_d_vld) seen = 1'b1;
        end
        check("wd_first_byte_seen", 32'(seen), 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wd_tx_vld", 32'(uart_tx_d_vld), 32'h0);
        check("rst_wd_tx_data", 32'(uart_tx_p_data), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        clear_q();
        repeat (40) @(negedge clk);
        check("rst_wd_fifo_flushed", 32'(tx_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
